// File: rtl/ifetch_buffer_if.sv
// +----------------------------------------------------------------------------+
// | Module      : ifetch_buffer_if                                             |
// | Description : Fetch-side bundle: imem request/response, redirect, decode.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface ifetch_buffer_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [3:0]  occupancy;

  modport master (
    input  redirect, redirect_pc, stall, imem_data, imem_valid,
    output imem_req, imem_addr, inst_out, inst_pc, inst_valid, occupancy
  );

  modport slave (
    output redirect, redirect_pc, stall, imem_data, imem_valid,
    input  imem_req, imem_addr, inst_out, inst_pc, inst_valid, occupancy
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_buffer.sv
// +----------------------------------------------------------------------------+
// | Module      : ifetch_buffer                                                |
// | Description : Sequential instruction fetch with prefetch FIFO and redirect |
// |               flush. Define IFETCH_BYPASS_EN for empty-queue bypass.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ifetch_buffer #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  ifetch_buffer_if.master  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic          pend;
  logic [31:0]   pend_pc;
  logic          drop;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          empty;
  logic [CW:0]   inflight;
  logic          req;
  logic          push;
  logic          byp;
  logic          pop;
  logic          head_pop;
  logic          write;
  logic          unused_ok;

  assign unused_ok = &{1'b0, bus.redirect_pc[1:0]};

  assign empty    = (count == '0);
  assign inflight = {1'b0, count} + {{CW{1'b0}}, pend};
  assign req      = !reset && !bus.redirect && (inflight < (CW+1)'(DEPTH));
  assign push     = bus.imem_valid && pend && !drop && !bus.redirect && !reset;

`ifdef IFETCH_BYPASS_EN
  assign byp = push && empty;
`else
  assign byp = 1'b0;
`endif

  assign pop      = bus.inst_valid && !bus.stall && !bus.redirect;
  assign head_pop = pop && !empty;
  // A bypassed entry consumed in the same cycle never occupies a slot.
  assign write    = push && !(byp && pop);

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = !empty || byp;
  assign bus.inst_out   = !empty ? data_q[head] : (byp ? bus.imem_data : 32'h0);
  assign bus.inst_pc    = !empty ? pc_q[head]   : (byp ? pend_pc       : 32'h0);
  assign bus.occupancy  = 4'(count);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= PC_INIT;
      pend     <= 1'b0;
      pend_pc  <= 32'h0;
      drop     <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      drop     <= pend;
      pend     <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (req) begin
        fetch_pc <= fetch_pc + 32'd4;
        pend     <= 1'b1;
        pend_pc  <= fetch_pc;
      end else begin
        pend     <= 1'b0;
      end
      // The flushed response is due the cycle after the flush; drop covers only that slot.
      drop  <= 1'b0;
      if (head_pop) head <= head + PW'(1);
      if (write)    tail <= tail + PW'(1);
      count <= count + CW'(write) - CW'(head_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (write) begin
      data_q[tail] <= bus.imem_data;
      pc_q[tail]   <= pend_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_buffer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_ifetch_buffer                                             |
// | Description : Directed + random bench for ifetch_buffer with queue model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_ifetch_buffer;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam logic [31:0] PC_WRAP = 32'hFFFF_FFF8;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 2;

  logic clk = 1'b0;
  logic reset;
  logic reset2;

  ifetch_buffer_if bus ();
  ifetch_buffer_if bus2 ();

  ifetch_buffer #(.DEPTH(DEPTH), .PC_INIT(PC_INIT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ifetch_buffer #(.DEPTH(DEPTH), .PC_INIT(PC_WRAP)) u_wrap (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: queue of PCs in program order plus fetch bookkeeping
  logic [31:0] mq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_pendpc;
  bit          m_pend;
  bit          m_drop;

  logic        s_req, s_valid, s2_valid;
  logic [31:0] s_addr, s_out, s_pc, s2_addr, s2_pc;
  logic [3:0]  s_occ;
  logic        req_cap, req2_cap, inject;
  logic [31:0] addr_cap, addr2_cap;
  logic [31:0] wseq [3];
  bit          found;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_check_step();
    bit          push, pop, exp_valid, exp_req;
    logic [31:0] exp_pc;
    int          occ;
    occ       = mq.size();
    exp_req   = !reset && !bus.redirect && (occ + int'(m_pend) < DEPTH);
    push      = bus.imem_valid && m_pend && !m_drop && !bus.redirect && !reset;
    exp_valid = (occ > 0) || (BYP && push);
    exp_pc    = (occ > 0) ? mq[0] : (exp_valid ? m_pendpc : 32'h0);
    chk("imem_req",   32'(bus.imem_req),   32'(exp_req));
    chk("imem_addr",  bus.imem_addr,       m_fetch);
    chk("inst_valid", 32'(bus.inst_valid), 32'(exp_valid));
    chk("inst_pc",    bus.inst_pc,         exp_pc);
    chk("inst_out",   bus.inst_out,        exp_valid ? memw(exp_pc) : 32'h0);
    chk("occupancy",  32'(bus.occupancy),  32'(occ));
    chk("occ_bound",  32'(bus.occupancy <= 4'(DEPTH)), 32'd1);
    pop = exp_valid && !bus.stall && !bus.redirect;
    if (reset) begin
      mq.delete();
      m_fetch = PC_INIT;
      m_pend  = 1'b0;
      m_drop  = 1'b0;
    end else if (bus.redirect) begin
      mq.delete();
      m_fetch = bus.redirect_pc & ~32'h3;
      m_drop  = m_pend;
      m_pend  = 1'b0;
    end else begin
      if (pop && occ > 0) void'(mq.pop_front());
      if (push && !(pop && occ == 0)) mq.push_back(m_pendpc);
      m_drop = 1'b0;
      if (exp_req) begin
        m_pendpc = m_fetch;
        m_fetch  = m_fetch + 32'd4;
        m_pend   = 1'b1;
      end else begin
        m_pend = 1'b0;
      end
    end
  endtask

  // one clock: sample + check at negedge, then play memory for the next cycle
  task automatic cycle();
    @(negedge clk);
    s_req    = bus.imem_req;
    s_addr   = bus.imem_addr;
    s_valid  = bus.inst_valid;
    s_out    = bus.inst_out;
    s_pc     = bus.inst_pc;
    s_occ    = bus.occupancy;
    s2_addr  = bus2.imem_addr;
    s2_pc    = bus2.inst_pc;
    s2_valid = bus2.inst_valid;
    model_check_step();
    req_cap   = bus.imem_req;
    addr_cap  = bus.imem_addr;
    req2_cap  = bus2.imem_req;
    addr2_cap = bus2.imem_addr;
    @(posedge clk);
    #1;
    bus.imem_valid  = req_cap || inject;
    bus.imem_data   = req_cap ? memw(addr_cap) : 32'hDEAD_BEEF;
    inject          = 1'b0;
    bus2.imem_valid = req2_cap;
    bus2.imem_data  = memw(addr2_cap);
  endtask

  initial begin
    reset = 1'b1;  reset2 = 1'b1;  inject = 1'b0;
    bus.redirect = 1'b0;  bus.redirect_pc = 32'h0;  bus.stall = 1'b0;
    bus.imem_valid = 1'b0;  bus.imem_data = 32'h0;
    bus2.redirect = 1'b0;  bus2.redirect_pc = 32'h0;  bus2.stall = 1'b0;
    bus2.imem_valid = 1'b0;  bus2.imem_data = 32'h0;
    m_fetch = PC_INIT;  m_pend = 1'b0;  m_drop = 1'b0;  m_pendpc = 32'h0;
    wseq[0] = 32'hFFFF_FFF8;  wseq[1] = 32'hFFFF_FFFC;  wseq[2] = 32'h0000_0000;
    @(posedge clk);
    #1;

    // reset state
    cycle();
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_addr", s_addr, PC_INIT);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_out", s_out, 32'h0);
    chk("rst_pc", s_pc, 32'h0);
    chk("rst_occ", 32'(s_occ), 32'd0);
    reset = 1'b0;

    // startup sequence, stall starts on the first valid cycle
    for (int k = 0; k <= LAT; k++) begin
      cycle();
      chk("seq_addr", s_addr, 32'(4 * k));
      chk("seq_req", 32'(s_req), 32'd1);
      chk("seq_valid", 32'(s_valid), (k == LAT) ? 32'd1 : 32'd0);
      if (k == LAT - 1) bus.stall = 1'b1;
    end
    chk("first_pc", s_pc, 32'h0);
    chk("first_out", s_out, 32'h1000);
    for (int j = 1; j < 10; j++) begin
      cycle();
      chk("stall_head_pc", s_pc, 32'h0);
      chk("stall_head_out", s_out, 32'h1000);
    end
    chk("stall_occ_full", 32'(s_occ), 32'(DEPTH));
    chk("stall_req_off", 32'(s_req), 32'd0);
    bus.stall = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cycle();
      chk("drain_valid", 32'(s_valid), 32'd1);
      chk("drain_pc", s_pc, 32'(4 * j));
      chk("drain_out", s_out, memw(32'(4 * j)));
    end

    // restart from 0, then redirect while the 0x14 fetch is pending
    bus.redirect = 1'b1;  bus.redirect_pc = 32'h0;
    cycle();
    bus.redirect = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      cycle();
      if (s_req && s_addr == 32'h14) found = 1'b1;
    end
    chk("found_req_14", 32'(found), 32'd1);
    bus.redirect = 1'b1;  bus.redirect_pc = 32'h0000_0103;
    cycle();
    chk("redir_no_req", 32'(s_req), 32'd0);
    bus.redirect = 1'b0;
    cycle();
    chk("redir_occ0", 32'(s_occ), 32'd0);
    chk("redir_addr", s_addr, 32'h100);
    for (int n = 0; n < LAT; n++) cycle();
    chk("redir_valid", 32'(s_valid), 32'd1);
    chk("redir_pc", s_pc, 32'h100);
    chk("redir_out", s_out, memw(32'h100));

    // redirect coinciding with a pop at occupancy 3
    bus.stall = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      cycle();
      if (s_occ == 4'd2) found = 1'b1;
    end
    chk("found_occ2", 32'(found), 32'd1);
    bus.redirect = 1'b1;  bus.redirect_pc = 32'h200;  bus.stall = 1'b0;
    cycle();
    chk("rp_occ3", 32'(s_occ), 32'd3);
    bus.redirect = 1'b0;
    cycle();
    chk("rp_empty_occ", 32'(s_occ), 32'd0);
    chk("rp_empty_valid", 32'(s_valid), 32'd0);

    // one-cycle reset mid-stream with two entries and a fetch in flight
    bus.stall = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      cycle();
      if (s_occ == 4'd1 && s_req) found = 1'b1;
    end
    chk("found_occ1", 32'(found), 32'd1);
    reset = 1'b1;  inject = 1'b1;
    cycle();
    chk("mr_occ2", 32'(s_occ), 32'd2);
    reset = 1'b0;  bus.stall = 1'b0;
    cycle();
    chk("mr_valid0", 32'(s_valid), 32'd0);
    chk("mr_addr", s_addr, PC_INIT);
    chk("mr_req", 32'(s_req), 32'd1);
    for (int n = 0; n < LAT; n++) cycle();
    chk("mr_first_pc", s_pc, PC_INIT);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bus.stall       = ($urandom % 3) == 0;
      bus.redirect    = ($urandom % 20) == 0;
      bus.redirect_pc = $urandom;
      reset           = ($urandom % 97) == 0;
      inject          = ($urandom % 10) == 0;
      cycle();
    end
    bus.redirect = 1'b0;  reset = 1'b0;  bus.stall = 1'b0;

    // 32-bit PC wrap on the second instance
    reset2 = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      cycle();
      if (k < 3) chk("wrap_addr", s2_addr, wseq[k]);
      if (k >= LAT) begin
        chk("wrap_valid", 32'(s2_valid), 32'd1);
        chk("wrap_pc", s2_pc, wseq[k - LAT]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifetch_buffer.md
# ifetch_buffer

Instruction fetch stage with a prefetch queue, sitting between the instruction memory and the IF/ID pipeline register of the pipelined MIPS core. It generates sequential fetch addresses and issues word reads to instruction memory. Returned instructions, each paired with its PC, are held in a small FIFO, so a decode-side stall does not throw away fetches already in flight. A redirect from the branch/jump logic flushes the queue, discards any in-flight response, and restarts fetch at the new target.

## Interface
- `DEPTH`, 4: FIFO entries; legal values 2, 4, 8.
- `PC_INIT`, 32'h0000_0000: fetch PC loaded on reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch target; bits [1:0] are ignored and forced to 0.
- `stall`  in  1  downstream not accepting; the head entry is held.
- `imem_req`  out  1  read request to instruction memory this cycle.
- `imem_addr`  out  32  word address of the request.
- `imem_data`  in  32  instruction returned by memory.
- `imem_valid`  in  1  `imem_data` is valid; asserted exactly one cycle after an accepted `imem_req`.
- `inst_out`  out  32  instruction at the head of the queue.
- `inst_pc`  out  32  PC of `inst_out`.
- `inst_valid`  out  1  head entry is valid.
- `occupancy`  out  4  number of valid FIFO entries, 0..DEPTH.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `pend`: 1 if a request was issued in the previous cycle.
  - `pend_pc`: PC of that request.
  - `drop`: the pending response must be discarded.
  - FIFO storage with head/tail pointers and a count.
- Request (combinational): `imem_req = !reset && !redirect && (count + pend) < DEPTH`; `imem_addr = fetch_pc`.
  - On a request: `fetch_pc <= fetch_pc + 4` (32-bit wrap from FFFF_FFFC to 0), `pend <= 1`, `pend_pc <= fetch_pc`.
  - With no request: `pend <= 0`.
- Push: when `imem_valid && pend && !drop && !redirect`, write {`imem_data`, `pend_pc`} at the tail.
- Pop: when `inst_valid && !stall`, advance the head.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop on an empty queue is a no-op.
  - Push on a full queue cannot occur by construction; the bench asserts this.
- Redirect (highest priority, below reset):
  - Count cleared, pointers cleared.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - `drop <= pend`; `pend <= 0`.
  - No request is issued in the redirect cycle.
  - A pop in the same cycle is ignored.
- `drop` is cleared in the cycle the discarded response arrives.
- `imem_valid` without `pend` is ignored.
- Reset mid-operation: the same flush as a redirect, but the target is `PC_INIT` and `drop` is 0. Late memory responses are ignored because `pend` is 0.

## Timing
- Reset values:
  - `imem_req` 0, `imem_addr` `PC_INIT`.
  - `inst_valid` 0, `inst_out` 0, `inst_pc` 0, `occupancy` 0.
  - `pend` 0, `drop` 0.
- First request: in the first cycle after `reset` deasserts.
- Latency from request to output:
  - Request in cycle N, response in N+1.
  - `inst_valid` in N+2 (N+1 with bypass, see Configuration).
- Throughput: one instruction per cycle while `stall` is 0.
- After a redirect in cycle R:
  - Request to the target in R+1.
  - `inst_valid` in R+3 (R+2 with bypass).
- `stall` held for k cycles: the queue fills to `DEPTH`, then `imem_req` stays 0 until a pop frees a slot. `imem_req` reasserts in the cycle after the pop.

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - If the FIFO is empty and a push occurs, {`imem_data`, `pend_pc`} drive `inst_out`/`inst_pc` combinationally and `inst_valid` = 1 in the same cycle.
  - If it is also popped (`!stall`), it is not written.
  - If `stall`, it is written normally.
- `IFETCH_BYPASS_EN` undefined: outputs come only from FIFO storage; a pushed entry becomes visible the following cycle.

## Test plan
- Reset release, `PC_INIT`=0, memory word i = 0x1000+i, `stall`=0:
  - `imem_addr` 0, 4, 8 … on consecutive cycles.
  - `inst_valid` from cycle 2 (cycle 1 with bypass).
  - `inst_out`/`inst_pc` = 0x1000/0, 0x1001/4, … with no gaps.
- Hold `stall`=1 for 10 cycles after the first valid:
  - `occupancy` saturates at 4; `imem_req` drops to 0.
  - Head stays 0x1000/0.
  - On release, entries drain in order 0, 4, 8, 12, 16 with no loss or duplication.
- `redirect`=1, `redirect_pc`=0x0000_0103 while a request to 0x14 is pending:
  - The 0x14 response is discarded.
  - Next `imem_addr` is 0x100; the first `inst_pc` is 0x100; `occupancy` is 0 in the cycle after the redirect.
- `redirect` and pop in the same cycle with `occupancy`=3: queue empty the next cycle; no entry from before the redirect ever appears.
- `PC_INIT`=0xFFFF_FFF8: `imem_addr` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; `inst_pc` follows the same sequence.
- Assert `reset` for 1 cycle mid-stream with `occupancy`=2 and a request pending:
  - `inst_valid` is 0 the next cycle; the stale `imem_valid` is ignored.
  - Fetch resumes at `PC_INIT`.
